// File: rtl/alu_seq_driver.sv
// Command sequencer for the 16-bit combinational arithmetic unit.
// Runs each command as one pass, or as two carry-chained passes for 2*DATA_W operands.
// The result is returned on a valid/ready response port.
// Optional build macro: ALU_SEQ_ILLEGAL_CHK_EN. When it is defined, selects 4'b1101..4'b1111
// are rejected with rsp_err=1 and never reach the ALU.
`timescale 1ns / 1ps

module alu_seq_driver #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SEL_W-1:0]    cmd_sel,
  input  logic                cmd_wide,
  input  logic [2*DATA_W-1:0] cmd_a,
  input  logic [2*DATA_W-1:0] cmd_b,
  input  logic                cmd_cin,
  output logic [SEL_W-1:0]    alu_sel,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_cin,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_cout,
  input  logic                alu_compare,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_cout,
  output logic                rsp_compare,
  output logic                rsp_err
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

  state_e                state_q, state_d;
  logic                  wide_q, wide_d;
  logic [DATA_W-1:0]     a_hi_q, a_hi_d;
  logic [DATA_W-1:0]     b_hi_q, b_hi_d;
  logic [SEL_W-1:0]      alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic                  alu_cin_q, alu_cin_d;
  logic [2*DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                  rsp_cout_q, rsp_cout_d;
  logic                  rsp_compare_q, rsp_compare_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  sel_illegal;

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  assign sel_illegal = (cmd_sel == SEL_W'(4'b1101)) || (cmd_sel == SEL_W'(4'b1110)) ||
                       (cmd_sel == SEL_W'(4'b1111));
`else
  assign sel_illegal = 1'b0;
`endif

  // Next-state decode; ALU operand registers are loaded for the state being entered.
  always_comb begin
    state_d       = state_q;
    wide_d        = wide_q;
    a_hi_d        = a_hi_q;
    b_hi_d        = b_hi_q;
    alu_sel_d     = alu_sel_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cin_d     = alu_cin_q;
    rsp_data_d    = rsp_data_q;
    rsp_cout_d    = rsp_cout_q;
    rsp_compare_d = rsp_compare_q;
    rsp_err_d     = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        alu_sel_d = '0;
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_cin_d = 1'b0;
        if (cmd_valid) begin
          wide_d        = cmd_wide;
          a_hi_d        = cmd_a[2*DATA_W-1:DATA_W];
          b_hi_d        = cmd_b[2*DATA_W-1:DATA_W];
          rsp_data_d    = '0;
          rsp_cout_d    = 1'b0;
          rsp_compare_d = 1'b0;
          rsp_err_d     = sel_illegal;
          if (sel_illegal) begin
            state_d = StResp;
          end else begin
            state_d   = StLo;
            alu_sel_d = cmd_sel;
            alu_a_d   = cmd_a[DATA_W-1:0];
            alu_b_d   = cmd_b[DATA_W-1:0];
            alu_cin_d = cmd_cin;
          end
        end
      end
      StLo: begin
        rsp_data_d    = {{DATA_W{1'b0}}, alu_out};
        rsp_cout_d    = alu_cout;
        rsp_compare_d = alu_compare;
        if (wide_q) begin
          state_d   = StHi;
          alu_a_d   = a_hi_q;
          alu_b_d   = b_hi_q;
          // The low-pass carry is registered straight into the upper pass carry-in.
          alu_cin_d = alu_cout;
        end else begin
          state_d = StResp;
        end
      end
      StHi: begin
        rsp_data_d    = {alu_out, rsp_data_q[DATA_W-1:0]};
        rsp_cout_d    = alu_cout;
        rsp_compare_d = rsp_compare_q & alu_compare;
        state_d       = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d   = StIdle;
          alu_sel_d = '0;
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_cin_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wide_q        <= 1'b0;
      a_hi_q        <= '0;
      b_hi_q        <= '0;
      alu_sel_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cin_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_cout_q    <= 1'b0;
      rsp_compare_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wide_q        <= wide_d;
      a_hi_q        <= a_hi_d;
      b_hi_q        <= b_hi_d;
      alu_sel_q     <= alu_sel_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cin_q     <= alu_cin_d;
      rsp_data_q    <= rsp_data_d;
      rsp_cout_q    <= rsp_cout_d;
      rsp_compare_q <= rsp_compare_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // cmd_ready is also gated by rst_n so nothing is offered while reset is held.
  assign cmd_ready   = rst_n && (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign alu_sel     = alu_sel_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_cout    = rsp_cout_q;
  assign rsp_compare = rsp_compare_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Bench for alu_seq_driver: a combinational ALU model plus a whole-command reference model.
`timescale 1ns / 1ps

module tb_alu_seq_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_sel;
  logic        cmd_wide;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_cin;
  logic [3:0]  alu_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic        alu_compare;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout;
  logic        rsp_compare;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  // Values seen during the first and second cycles after acceptance.
  logic [15:0] lo_a, lo_out;
  logic [3:0]  lo_sel;
  logic        lo_cin, lo_cout, hi_cin;

  always #5 clk = ~clk;

  alu_seq_driver #(.DATA_W(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_wide(cmd_wide),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_compare(rsp_compare), .rsp_err(rsp_err)
  );

  // 16-bit ALU stand-in: 0 and, 1 add, 2 sub (a+~b+cin), 3 xor, others or with cout=cin.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    unique case (alu_sel)
      4'd0:    alu_sum = {1'b0, alu_a & alu_b};
      4'd1:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
      4'd2:    alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(alu_cin);
      4'd3:    alu_sum = {1'b0, alu_a ^ alu_b};
      default: alu_sum = {alu_cin, alu_a | alu_b};
    endcase
    alu_out     = alu_sum[15:0];
    alu_cout    = alu_sum[16];
    alu_compare = (alu_a == alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-command reference: full-width arithmetic, no notion of passes.
  task automatic model(input logic [3:0] sel, input logic wide, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, output logic [31:0] d,
                       output logic co, output logic cmp, output logic err, output int lat);
    logic [31:0] mask, am, bm;
    logic [32:0] s;
    mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    am   = a & mask;
    bm   = b & mask;
    err  = 1'b0;
    lat  = wide ? 3 : 2;
    cmp  = (am == bm);
    s    = '0;
    co   = 1'b0;
    d    = '0;
    unique case (sel)
      4'd0: d = am & bm;
      4'd1: s = {1'b0, am} + {1'b0, bm} + 33'(cin);
      4'd2: s = {1'b0, am} + {1'b0, ~bm & mask} + 33'(cin);
      4'd3: d = am ^ bm;
      default: begin
        d  = am | bm;
        co = cin;
      end
    endcase
    if (sel == 4'd1 || sel == 4'd2) begin
      d  = s[31:0] & mask;
      co = wide ? s[32] : s[16];
    end
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    if (sel >= 4'd13) begin
      d   = '0;
      co  = 1'b0;
      cmp = 1'b0;
      err = 1'b1;
      lat = 1;
    end
`endif
  endtask

  // Issue one command from IDLE, check latency and response, hold off rsp_ready for bp cycles.
  task automatic run_cmd(input logic [3:0] sel, input logic wide, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input int bp);
    logic [31:0] ed, held;
    logic        eco, ecmp, eerr;
    int          elat, lat;
    model(sel, wide, a, b, cin, ed, eco, ecmp, eerr, elat);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_wide  = wide;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    cmd_sel   = 4'($urandom);
    lat       = 1;
    lo_a = alu_a; lo_out = alu_out; lo_sel = alu_sel; lo_cin = alu_cin; lo_cout = alu_cout;
    hi_cin = 1'b0;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 2) hi_cin = alu_cin;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("rsp_data", rsp_data, ed);
    chk("rsp_cout", 32'(rsp_cout), 32'(eco));
    chk("rsp_compare", 32'(rsp_compare), 32'(ecmp));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    if (eerr) chk("illegal_alu_a", 32'(lo_a), 32'd0);
    else chk("lo_alu_a", 32'(lo_a), a & 32'hFFFF);
    held = rsp_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, held);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_wide = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu", {alu_sel, alu_a, 11'd0, alu_cin}, 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_rsp", {rsp_data[30:0], rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Narrow add 3+4.
    run_cmd(4'b0001, 1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 0);
    chk("narrow_lo_cin", 32'(lo_cin), 32'd0);
    chk("narrow_lo_sel", 32'(lo_sel), 32'd1);

    // Wide add with carry rippling into the upper pass.
    run_cmd(4'b0001, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
    chk("wide_lo_out", 32'(lo_out), 32'd0);
    chk("wide_lo_cout", 32'(lo_cout), 32'd1);
    chk("wide_hi_cin", 32'(hi_cin), 32'd1);
    chk("wide_rsp_data", rsp_data, 32'h0001_0000);

    // Backpressure for five cycles.
    run_cmd(4'b0001, 1'b0, 32'h0000_1234, 32'h0000_0011, 1'b1, 5);

    // Back-to-back with cmd_valid held and rsp_ready held high.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_sel = 4'd1; cmd_wide = 1'b0; cmd_cin = 1'b0;
    cmd_a = 32'd10; cmd_b = 32'd20;
    @(negedge clk);
    cmd_a = 32'h100; cmd_b = 32'h200;
    chk("b2b_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp1_data", rsp_data, 32'd30);
    @(negedge clk);
    chk("b2b_idle_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_idle_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_taken", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp2_data", rsp_data, 32'h300);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_done", 32'(rsp_valid), 32'd0);

    // Reset during the upper pass of a wide command.
    cmd_valid = 1'b1; cmd_sel = 4'd1; cmd_wide = 1'b1;
    cmd_a = 32'h1234_5678; cmd_b = 32'h1111_1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_alu", {alu_sel, alu_a, 11'd0, alu_cin}, 32'd0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    // Reserved select: rejected early when the check is built in, sequenced otherwise.
    run_cmd(4'b1110, 1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0, 0);

    // Random commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_cmd(4'($urandom_range(0, 15)), 1'($urandom), ra, rb, 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_driver.md
Name: alu_seq_driver

Overview:
- Command-side sequencer for the 16-bit combinational arithmetic unit. It drives that unit's sel/operand/carry-in inputs and consumes its result, carry-out and compare outputs.
- Accepts operation commands on a valid/ready handshake. Executes each as one 16-bit pass or two chained passes (32-bit, carry rippled between passes), registers the result, and returns it on a valid/ready response port.
- Sits between the instruction/control path and the arithmetic unit.

Parameters:
- DATA_W, 16, width of one ALU pass; must match arithmetic unit width.
- SEL_W, 4, width of operation select.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_sel  in  SEL_W  operation select passed to ALU
- cmd_wide  in  1  1 = two-pass 2*DATA_W operation, 0 = single pass
- cmd_a  in  2*DATA_W  operand A (upper half ignored when narrow)
- cmd_b  in  2*DATA_W  operand B (upper half ignored when narrow)
- cmd_cin  in  1  carry-in for first pass
- alu_sel  out  SEL_W  to ALU sel
- alu_a  out  DATA_W  to ALU in_a
- alu_b  out  DATA_W  to ALU in_b
- alu_cin  out  1  to ALU cin
- alu_out  in  DATA_W  from ALU ArOut
- alu_cout  in  1  from ALU cout
- alu_compare  in  1  from ALU compare
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_data  out  2*DATA_W  result; upper half 0 for narrow
- rsp_cout  out  1  carry-out of final pass
- rsp_compare  out  1  AND of compare over all passes
- rsp_err  out  1  illegal-select flag (see Optional Feature)

Behaviour:
- Reset: rst_n sampled on rising clk only.
  - While low: state=IDLE; cmd_ready=0; rsp_valid=0.
  - rsp_data, rsp_cout, rsp_compare, rsp_err = 0.
  - alu_sel, alu_a, alu_b, alu_cin = 0.
  - Command registers cleared.
- States: IDLE, LO, HI, RESP.
- IDLE:
  - cmd_ready=1 (0 while rst_n low); ALU outputs driven 0.
  - On cmd_valid&cmd_ready: capture sel, wide, a, b, cin; go to LO.
- LO:
  - alu_sel=sel; alu_a=a[DATA_W-1:0]; alu_b=b[DATA_W-1:0]; alu_cin=cin.
  - At clock edge: register alu_out into rsp_data low half, alu_cout into carry register, alu_compare into compare register.
  - Next state: HI if wide, else RESP. Narrow: upper rsp_data half=0.
- HI:
  - alu_sel=sel; alu_a, alu_b = upper halves; alu_cin = carry registered in LO.
  - At clock edge: register alu_out into upper half; rsp_cout=alu_cout; rsp_compare = LO compare & alu_compare. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_* stable until handshake; cmd_ready=0.
  - ALU outputs hold last-pass values.
  - On rsp_ready: rsp_valid drops next cycle; go to IDLE.
- Latency, accept edge = T:
  - Narrow: rsp_valid high from cycle T+2.
  - Wide: rsp_valid high from cycle T+3.
  - With rsp_ready held 1, next command accepted one cycle after response handshake (one IDLE cycle).
- Only one command in flight; no queueing.
- ALU result sampling: alu_* outputs are registered state-decoded values. The ALU is purely combinational, so alu_out is sampled the same cycle the operands are presented.
- cmd_valid while not ready: ignored; the upstream holds it.
- Reset mid-operation (any state): abort. Next cycle all outputs at reset values; no response issued for the aborted command.
- rsp_ready asserted outside RESP: ignored.

Optional Feature:
- Macro ALU_SEQ_ILLEGAL_CHK_EN.
- Defined:
  - Selects 4'b1101, 4'b1110 and 4'b1111 are illegal (no defined ALU operation).
  - On accept of an illegal select: skip LO/HI and go IDLE->RESP directly; response at T+1.
  - Response values: rsp_data=0, rsp_cout=0, rsp_compare=0, rsp_err=1.
  - ALU outputs stay 0.
  - rsp_err=0 for legal selects.
- Undefined: all selects sequenced normally; rsp_err tied 0.

Test Plan:
- Bench ALU model: sel 0001 = a+b+cin.
- Narrow add: sel=0001, a=0x0003, b=0x0004, cin=0 -> rsp_valid at T+2; rsp_data=0x00000007; rsp_cout=0; alu_cin=0 during LO.
- Wide add with carry chain: sel=0001, wide=1, a=0x0000FFFF, b=0x00000001 -> LO alu_out=0x0000 with cout=1; HI alu_cin=1; rsp_data=0x00010000 at T+3; rsp_cout=0.
- Backpressure: narrow add, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held stable for 5 cycles; cmd_ready=0 throughout; handshake on cycle 6.
- Back-to-back: cmd_valid held with two narrow commands, rsp_ready=1 -> second command accepted one cycle after first response handshake; responses in order.
- Reset mid-operation: wide command, rst_n=0 during HI -> next cycle rsp_valid=0, all alu_* outputs 0, cmd_ready=0. After rst_n=1, cmd_ready=1 and no stale response is issued.
- ALU_SEQ_ILLEGAL_CHK_EN defined, sel=1110 -> rsp_valid at T+1 with rsp_err=1 and rsp_data=0. Macro undefined, same stimulus -> normal T+2 response with rsp_err=0.
